column_serializer: RTL

COLUMN_SERIALIZER -- requirements
Module: column_serializer

---
 rtl/cnn_pkg.sv | 8 +
 rtl/column_serializer.sv | 118 +++++++++++
 2 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared element width and signed element type for the CNN datapath
package cnn_pkg;

    localparam int CNN_DATA_WIDTH = 16;

    typedef logic signed [CNN_DATA_WIDTH-1:0] elem_t;

endpackage

// File: rtl/column_serializer.sv
// rtl/column_serializer.sv - captures a parallel column and emits it one element per handshake
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   col_valid, col_ready  column handshake (col_ready is combinational)
//   col_data              COLUMN_SIZE elements of DATA_WIDTH, element 0 in the top bits
//   out_valid, out_ready  serial element handshake
//   out_data              current element (clamped at zero when COLUMN_SERIALIZER_RELU_EN is defined)
//   out_index, out_last   position of out_data in the column, high on element COLUMN_SIZE-1
//
// Optional build macro: COLUMN_SERIALIZER_RELU_EN
module column_serializer
    import cnn_pkg::*;
#(
    parameter int COLUMN_SIZE = 24,
    parameter int DATA_WIDTH  = CNN_DATA_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 col_valid,
    output logic                                 col_ready,
    input  logic signed [COLUMN_SIZE*DATA_WIDTH-1:0] col_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(COLUMN_SIZE)-1:0]       out_index,
    output logic                                 out_last
);

    localparam int IDX_W = $clog2(COLUMN_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COLUMN_SIZE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t state;

    logic signed [DATA_WIDTH-1:0] buffer [COLUMN_SIZE];
    logic signed [DATA_WIDTH-1:0] cur_elem;

    logic out_fire;
    logic col_accept;

    assign out_fire   = out_valid && out_ready;
    // A new column may land on the same edge the last element leaves,
    // which keeps back-to-back columns free of bubbles.
    assign col_ready  = (state == IDLE) || (out_fire && out_last);
    assign col_accept = col_valid && col_ready;

    // Column buffer: col_data is only looked at on an accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < COLUMN_SIZE; k++) begin
                buffer[k] <= '0;
            end
        end else if (col_accept) begin
            for (int k = 0; k < COLUMN_SIZE; k++) begin
                buffer[k] <= col_data[(COLUMN_SIZE-1-k)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Control FSM with registered valid/index/last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (col_accept) begin
                        state     <= SEND;
                        out_valid <= 1'b1;
                        out_index <= '0;
                        out_last  <= (LAST_IDX == '0);
                    end
                end
                SEND: begin
                    if (col_accept) begin
                        // Only reachable on the last handshake: restart on the new column.
                        out_valid <= 1'b1;
                        out_index <= '0;
                        out_last  <= (LAST_IDX == '0);
                    end else if (out_fire) begin
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_index <= '0;
                            out_last  <= 1'b0;
                        end else begin
                            out_index <= out_index + 1'b1;
                            out_last  <= ((out_index + 1'b1) == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_index <= '0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

    assign cur_elem = buffer[out_index];

`ifdef COLUMN_SERIALIZER_RELU_EN
    assign out_data = cur_elem[DATA_WIDTH-1] ? '0 : cur_elem;
`else
    assign out_data = cur_elem;
`endif

endmodule
